// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - two-flop synchroniser and counter debounce filter with edge pulses.
// Optional rejected-glitch counter on Bounce_count when SWITCH_BOUNCE_CNT_EN is defined.
module switch_debounce #(
  parameter int STABLE_CYCLES = 200000,
  parameter int CNT_W         = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        Switch,
  output logic        Switch_state,
  output logic        Switch_rise,
`ifdef SWITCH_BOUNCE_CNT_EN
  output logic        Switch_fall,
  output logic [15:0] Bounce_count
`else
  output logic        Switch_fall
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync0_q, sync0_d;
  logic             sync1_q, sync1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             state_q, state_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Any cycle where the synchronised input matches the output restarts the count.
  always_comb begin
    sync0_d = Switch;
    sync1_d = sync0_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    if (sync1_q == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      state_d = sync1_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    rise_d = state_d & ~state_q;
    fall_d = ~state_d & state_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      cnt_q   <= '0;
      state_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign Switch_state = state_q;
  assign Switch_rise  = rise_q;
  assign Switch_fall  = fall_q;

`ifdef SWITCH_BOUNCE_CNT_EN
  logic [15:0] bcnt_q, bcnt_d;

  // A glitch is a count abandoned part-way, not one completed by an output flip.
  always_comb begin
    bcnt_d = bcnt_q;
    if ((sync1_q == state_q) && (cnt_q != '0) && (bcnt_q != 16'hFFFF)) begin
      bcnt_d = bcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcnt_q <= 16'd0;
    end else begin
      bcnt_q <= bcnt_d;
    end
  end

  assign Bounce_count = bcnt_q;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// tb/tb_switch_debounce.sv - directed vector table plus hand sequences for switch_debounce.
module tb_switch_debounce;

  localparam int S = 16;

  logic clk;
  logic reset_n;
  logic sw;
  logic state;
  logic rise;
  logic fall;
`ifdef SWITCH_BOUNCE_CNT_EN
  logic [15:0] bounce_count;
`endif

  switch_debounce #(.STABLE_CYCLES(S), .CNT_W(24)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .Switch       (sw),
    .Switch_state (state),
    .Switch_rise  (rise),
`ifdef SWITCH_BOUNCE_CNT_EN
    .Switch_fall  (fall),
    .Bounce_count (bounce_count)
`else
    .Switch_fall  (fall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic sw;
    int   cycles;
    int   exp_state;
    int   exp_rise;
    int   exp_fall;
  } vec_t;

  vec_t vecs [11];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int r, f, both, viol;

    // state starts 0; a clean edge flips the output on the 18th clock
    vecs[0]  = '{1'b0, 100, 0, 0, 0};
    vecs[1]  = '{1'b1,  17, 0, 0, 0};
    vecs[2]  = '{1'b1,   1, 1, 1, 0};
    vecs[3]  = '{1'b1,  20, 1, 0, 0};
    vecs[4]  = '{1'b0,  15, 1, 0, 0};
    vecs[5]  = '{1'b1,  20, 1, 0, 0};
    vecs[6]  = '{1'b0,  16, 1, 0, 0};
    vecs[7]  = '{1'b1,   2, 0, 0, 1};
    vecs[8]  = '{1'b1,  15, 0, 0, 0};
    vecs[9]  = '{1'b1,   1, 1, 1, 0};
    vecs[10] = '{1'b0,   5, 1, 0, 0};

    reset_n = 1'b0;
    sw      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", int'(state), 0);
    check("reset_rise",  int'(rise),  0);
    check("reset_fall",  int'(fall),  0);
    reset_n = 1'b1;

    both = 0;
    for (int i = 0; i < 11; i++) begin
      sw = vecs[i].sw;
      r = 0;
      f = 0;
      for (int c = 0; c < vecs[i].cycles; c++) begin
        step();
        r += int'(rise);
        f += int'(fall);
        if (rise && fall) both++;
      end
      check($sformatf("vec%0d_state", i), int'(state), vecs[i].exp_state);
      check($sformatf("vec%0d_rise",  i), r, vecs[i].exp_rise);
      check($sformatf("vec%0d_fall",  i), f, vecs[i].exp_fall);
    end
    check("rise_fall_exclusive", both, 0);

    // Asynchronous reset clears a high output without waiting for a clock
    sw = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_state", int'(state), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset with counter at 10 discards progress
    for (int c = 0; c < 12; c++) step();
    check("midcount_state_before", int'(state), 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("midcount_reset_state", int'(state), 0);
    check("midcount_reset_rise",  int'(rise),  0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 17; c++) step();
    check("post_reset_17", int'(state), 0);
    step();
    check("post_reset_18_state", int'(state), 1);
    check("post_reset_18_rise",  int'(rise),  1);
    step();
    check("post_reset_19_rise",  int'(rise),  0);

    sw = 1'b0;
    for (int c = 0; c < 20; c++) step();
    check("pre_toggle_state", int'(state), 0);

    // 1000 toggles of 10 clocks each never reach the output
    viol = 0;
    for (int t = 0; t < 1000; t++) begin
      sw = ~sw;
      for (int c = 0; c < 10; c++) begin
        step();
        if (state || rise || fall) viol++;
      end
    end
    check("toggle_no_change", viol, 0);
    sw = 1'b1;
    r = 0;
    for (int c = 0; c < 17; c++) begin
      step();
      r += int'(rise);
    end
    check("hold_17_state", int'(state), 0);
    step();
    r += int'(rise);
    check("hold_18_state", int'(state), 1);
    step();
    r += int'(rise);
    check("hold_rise_count", r, 1);

`ifdef SWITCH_BOUNCE_CNT_EN
    sw = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) step();
    check("bounce_start", int'(bounce_count), 0);
    for (int g = 0; g < 5; g++) begin
      sw = 1'b1;
      for (int c = 0; c < 3; c++) step();
      sw = 1'b0;
      for (int c = 0; c < 8; c++) step();
    end
    check("bounce_count_5", int'(bounce_count), 5);
    check("bounce_state", int'(state), 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("bounce_reset", int'(bounce_count), 0);
    @(negedge clk);
    reset_n = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
Debounces one mechanical switch/pushbutton input for the pong game's paddle controls. The raw asynchronous input is synchronised into the system clock domain. A clean level is produced only after the input has held one value for a programmable number of consecutive clocks. Single-cycle edge pulses are also provided for the downstream game FSM.

Parameters:
STABLE_CYCLES, 200000, consecutive clocks the synchronised input must differ from the output before the output flips (2 ms at 100 MHz); legal range 2..2^24-1.
CNT_W, 24, counter width; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
clk  input  1  system clock (100 MHz nominal); all logic on rising edge.
reset_n  input  1  asynchronous, active-low reset.
Switch  input  1  raw, bouncy, asynchronous switch level.
Switch_state  output  1  debounced level, registered.
Switch_rise  output  1  one-cycle pulse when Switch_state goes 0->1.
Switch_fall  output  1  one-cycle pulse when Switch_state goes 1->0.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (reset_n). Assertion immediately clears all state; deassertion takes effect on the next clk edge.
- Reset values: sync_ff0 = 0, sync_ff1 = 0, counter = 0, Switch_state = 0, Switch_rise = 0, Switch_fall = 0.
- Synchroniser: 2-flop chain, Switch -> sync_ff0 -> sync_ff1. Only sync_ff1 feeds the filter.
- Each clk edge:
  - If sync_ff1 == Switch_state: counter <= 0.
  - Else if counter == STABLE_CYCLES-1: Switch_state <= sync_ff1; counter <= 0.
  - Else: counter <= counter + 1.
- Result: Switch_state flips on the STABLE_CYCLES-th consecutive edge at which sync_ff1 differs from Switch_state.
- Latency from a clean raw edge to the output change is STABLE_CYCLES+2 clocks.
- Any return of sync_ff1 to the current output value, even for one cycle, restarts the count from 0. Bounce shorter than STABLE_CYCLES never reaches the output.
- Switch_rise / Switch_fall: high for exactly the one cycle after the edge at which Switch_state changes, in the matching direction. They are never both high. They are 0 otherwise.
- Counter never wraps: it is bounded by STABLE_CYCLES-1.
- Reset mid-count discards progress. After release, the output is 0 regardless of Switch. A Switch held at 1 through reset produces Switch_state = 1 STABLE_CYCLES+2 clocks after release, with one Switch_rise pulse.
- No combinational path from Switch to any output.

Optional Feature:
SWITCH_BOUNCE_CNT_EN
- Defined: adds output port Bounce_count (input, 16-bit → correction: output, 16-bit).
  - Increments, saturating at 16'hFFFF, each time the counter is cleared from a nonzero value because sync_ff1 returned to Switch_state (a rejected glitch).
  - Reset value 0.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, STABLE_CYCLES=16, clk 10 ns, Switch=0 -> Switch_state=0; no pulses for 100 cycles.
- Switch toggled every 100 ns (10 clk) for 1000 toggles with STABLE_CYCLES=16 -> Switch_state stays 0; no pulses. Then hold Switch=1 -> Switch_state=1 exactly 18 clocks after the last toggle; Switch_rise high exactly 1 cycle.
- Hold Switch=1, apply 15-cycle low glitch -> no change. Apply a 16-cycle low pulse -> Switch_state=0 and Switch_fall pulses once; returns to 1 only after 16 more stable high cycles.
- Default STABLE_CYCLES=200000, 100 ns bounce burst for 1 ms, then 50 ms high -> output rises 2.00002 ms after bounce ends; remains 1 for the rest of the 50 ms.
- Assert reset_n low mid-count (counter=10) with Switch=1 -> outputs 0 immediately. After release, Switch_state=1 after 18 clocks.
- SWITCH_BOUNCE_CNT_EN defined: five 3-cycle glitches -> Bounce_count=5. Reset -> 0.
